// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events onto n_voice envelope slices,
// with retrigger, free/releasing reuse and oldest-voice stealing with a gate gap.
module voice_alloc #(
  parameter int n_voice   = 4,
  parameter int nbit_note = 7,
  parameter int steal_gap = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [nbit_note-1:0]           ev_note,
  input  logic [n_voice-1:0]             voice_active,
  output logic [n_voice-1:0]             gate,
  output logic [n_voice*nbit_note-1:0]   note_v,
  output logic                           steal
);

  localparam int aw = (n_voice > 1) ? $clog2(n_voice) : 1;
  localparam logic [3:0] gap_load = 4'(steal_gap - 1);
  localparam logic [aw-1:0] age_oldest = aw'(n_voice - 1);

  typedef enum logic [1:0] {IDLE, DECIDE, GAP} state_t;

  state_t                state_reg, state_next;
  logic                  on_reg;
  logic [nbit_note-1:0]  evnote_reg;
  logic [n_voice-1:0]    gate_reg;
  logic [nbit_note-1:0]  note_reg [n_voice];
  logic [aw-1:0]         age_reg [n_voice];
  logic [aw-1:0]         sel_reg;
  logic [3:0]            cnt_reg;
  logic                  steal_reg;

  logic [n_voice-1:0]    match_v, free_v, rel_v, old_v;
  logic [aw-1:0]         pick;
  logic                  do_clear, do_set, do_write, do_age, do_steal;

  genvar gi;
  generate
    for (gi = 0; gi < n_voice; gi++) begin : g_voice
      assign match_v[gi] = gate_reg[gi] & (note_reg[gi] == evnote_reg);
      assign free_v[gi]  = ~gate_reg[gi] & ~voice_active[gi];
      assign rel_v[gi]   = ~gate_reg[gi] & voice_active[gi];
      assign old_v[gi]   = (age_reg[gi] == age_oldest);
      assign note_v[gi*nbit_note +: nbit_note] = note_reg[gi];
    end
  endgenerate

  assign ev_ready = (state_reg == IDLE) & ~rst;
  assign gate     = gate_reg;
  assign steal    = steal_reg;

  function automatic logic [aw-1:0] lowest(input logic [n_voice-1:0] v);
    logic [aw-1:0] r;
    r = '0;
    for (int i = n_voice - 1; i >= 0; i--) begin
      if (v[i]) r = aw'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pick       = '0;
    do_clear   = 1'b0;
    do_set     = 1'b0;
    do_write   = 1'b0;
    do_age     = 1'b0;
    do_steal   = 1'b0;
    case (state_reg)
      IDLE: if (ev_valid) state_next = DECIDE;
      DECIDE: begin
        state_next = IDLE;
        if (!on_reg) begin
          if (|match_v) begin
            pick     = lowest(match_v);
            do_clear = 1'b1;
          end
        end else begin
          do_age = 1'b1;
          if (|match_v) begin
            pick       = lowest(match_v);
            do_clear   = 1'b1;
            state_next = GAP;
          end else if (|free_v) begin
            pick     = lowest(free_v);
            do_write = 1'b1;
            do_set   = 1'b1;
          end else if (|rel_v) begin
            // Releasing envelope re-enters attack directly, so no gap
            pick     = lowest(rel_v);
            do_write = 1'b1;
            do_set   = 1'b1;
          end else begin
            pick       = lowest(old_v);
            do_clear   = 1'b1;
            do_write   = 1'b1;
            do_steal   = 1'b1;
            state_next = GAP;
          end
        end
      end
      GAP: begin
        pick = sel_reg;
        if (cnt_reg == 4'd0) begin
          do_set     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      on_reg     <= 1'b0;
      evnote_reg <= '0;
      gate_reg   <= '0;
      sel_reg    <= '0;
      cnt_reg    <= 4'd0;
      steal_reg  <= 1'b0;
      for (int j = 0; j < n_voice; j++) begin
        note_reg[j] <= '0;
        age_reg[j]  <= aw'(j);
      end
    end else begin
      steal_reg <= do_steal;
      if (state_reg == IDLE && ev_valid) begin
        on_reg     <= ev_on;
        evnote_reg <= ev_note;
      end
      if (state_reg == DECIDE) begin
        sel_reg <= pick;
        cnt_reg <= gap_load;
      end else if (state_reg == GAP && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end
      for (int j = 0; j < n_voice; j++) begin
        if (pick == aw'(j)) begin
          if (do_clear) gate_reg[j] <= 1'b0;
          if (do_set)   gate_reg[j] <= 1'b1;
          if (do_write) note_reg[j] <= evnote_reg;
        end
        // Move-to-front: selected voice becomes youngest, younger ones age by one
        if (do_age) begin
          if (pick == aw'(j))                 age_reg[j] <= '0;
          else if (age_reg[j] < age_reg[pick]) age_reg[j] <= age_reg[j] + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/voice_alloc.md
# voice_alloc

Polyphonic voice allocator for the synth. It accepts note-on and note-off events over a valid/ready handshake and assigns each note to one of `n_voice` envelope+oscillator voice slices. Each slice has its own `adsr_v` instance. The allocator drives each slice's gate (the envelope `vin`) and note number, and reads back each slice's envelope-active flag (the envelope `vout`). When all voices are busy it steals the least-recently-allocated voice, forcing a short gate gap so that the envelope restarts its attack.

## Interface
Parameters:
- `n_voice`, 4: number of voice slices (2..8).
- `nbit_note`, 7: note number width.
- `steal_gap`, 2: cycles the gate is held low on retrigger or steal (1..15).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ev_valid`  in  1  event present.
- `ev_ready`  out  1  allocator can accept an event.
- `ev_on`  in  1  1 = note-on, 0 = note-off.
- `ev_note`  in  `nbit_note`  note number.
- `voice_active`  in  `n_voice`  per-voice envelope active (envelope not idle).
- `gate`  out  `n_voice`  per-voice envelope gate.
- `note_v`  out  `n_voice*nbit_note`  per-voice note; voice k occupies bits [k*nbit_note +: nbit_note].
- `steal`  out  1  one-cycle pulse when a gated voice is stolen.

## Operation
- **Event capture:** an event is accepted on a rising edge with `ev_valid & ev_ready`. `ev_on` and `ev_note` are registered at that edge.
- **FSM states:** IDLE, DECIDE, GAP. `ev_ready` = (state == IDLE) & ~`rst`.
- **IDLE → DECIDE** on accept.

DECIDE (one cycle) evaluates the registered event against the current `gate`, `note_v`, and `voice_active`.

Note-off:
- Target is the lowest-index voice with `gate`=1 and matching note. Its gate is cleared and the FSM returns to IDLE.
- With no match, nothing changes and the FSM returns to IDLE.

Note-on voice selection, first match wins:
1. Retrigger: lowest-index voice with `gate`=1 and matching note. Clear its gate, go to GAP.
2. Free voice: lowest-index voice with `gate`=0 and `voice_active`=0. Write the note, set the gate, go to IDLE.
3. Releasing voice: lowest-index voice with `gate`=0 and `voice_active`=1. Write the note, set the gate, go to IDLE. No gap is needed because the envelope re-enters attack from release.
4. Steal: the voice with age == `n_voice`-1. Clear its gate, write the note, pulse `steal`, go to GAP.

Note-on age update:
- Every note-on that selects voice k updates the ages.
- Each voice j with age[j] < age[k] increments its age.
- age[k] becomes 0.
- Ages always remain a permutation of 0..`n_voice`-1.

GAP:
- A counter loads `steal_gap`-1 on entry and decrements each cycle.
- At count 0, set the selected voice's gate and go to IDLE.
- During GAP the voice's gate stays 0 and other voices are untouched.

Note-off does not change ages.

## Timing
- **Reset values:** `gate`=0, all `note_v`=0, `steal`=0, state IDLE, age[j]=j (voice `n_voice`-1 oldest), GAP counter 0. `ev_ready`=0 while `rst` is high.
- **Reset mid-operation** returns everything to reset values immediately. The pending event is discarded.
- **Latency:** event accepted at edge N; `gate`/`note_v` update at edge N+1 (DECIDE).
- **Free, releasing, or note-off:** `ev_ready` is high again after edge N+1, so the next event can be accepted at edge N+2. Throughput is one event per 2 cycles.
- **Retrigger/steal:** the gate falls at N+1, is low for exactly `steal_gap` cycles, and rises at edge N+1+`steal_gap`. `ev_ready` returns after that same edge. `steal` is high for the single cycle following edge N+1.
- **Snapshot:** `voice_active` is sampled only in DECIDE. Changes during GAP do not alter the selection.
- **Wide-voice note_v:** `note_v` of a stolen voice changes at N+1, at the same time as its gate falls.

## Test plan
- **Basic allocation and note-off:** after reset, hold `voice_active`=0. Note-on 60 at edge N → `gate`=0001 and voice0 note 60 after N+1; `ev_ready` is low for exactly one cycle. Then note-off 60 → `gate`=0000.
- **Fill and steal:** note-on 60, 62, 64, 65 with `voice_active` following `gate`, giving `gate`=1111. Note-on 67 → voice0 (oldest) is stolen: gate0 low for 2 cycles, then high with note 67; `steal` pulses once.
- **Releasing reuse:** voices 0..3 allocated. Note-off 62 (voice1) while `voice_active`[1] stays 1. Note-on 70 → voice1 is gated again immediately (no gap) with note 70; no `steal` pulse.
- **Retrigger:** note-on 60 twice → second event drops gate0 for `steal_gap` cycles and then re-raises it; no other voice changes and `steal` stays 0.
- **Unmatched note-off and backpressure:** note-off 99 with no match → no output change. Hold `ev_valid` high continuously → events are accepted only while `ev_ready` is high, and none are lost or duplicated.
- **Reset mid-GAP:** assert `rst` during the steal gap → `gate`=0, ages reset to j, and the allocator accepts a new event on the first edge after release.
